// File: rtl/div_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_arbiter_if
// Description : Bundle for the divider issue arbiter. It carries the requester
//               ops, the divider issue and return path, the result port and
//               the sticky sync error. The slave modport is the arbiter's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_issue_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 6
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                     flush;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*XLEN-1:0]  req_dividend;
  logic [NUM_REQ*XLEN-1:0]  req_divisor;
  logic [NUM_REQ*2-1:0]     req_type;
  logic [NUM_REQ*TAG_W-1:0] req_tag;

  logic                     div_valid_in;
  logic [XLEN-1:0]          div_dividend;
  logic [XLEN-1:0]          div_divisor;
  logic [1:0]               div_type;
  logic [XLEN-1:0]          div_quotient;
  logic                     div_valid_out;

  logic                     res_valid;
  logic                     res_ready;
  logic [XLEN-1:0]          res_data;
  logic [TAG_W-1:0]         res_tag;
  logic [ID_W-1:0]          res_req_id;
  logic                     err_sync;

  modport slave (
    input  flush, req_valid, req_dividend, req_divisor, req_type, req_tag,
    input  div_quotient, div_valid_out, res_ready,
    output req_ready, div_valid_in, div_dividend, div_divisor, div_type,
    output res_valid, res_data, res_tag, res_req_id, err_sync
  );

  modport master (
    output flush, req_valid, req_dividend, req_divisor, req_type, req_tag,
    output div_quotient, div_valid_out, res_ready,
    input  req_ready, div_valid_in, div_dividend, div_divisor, div_type,
    input  res_valid, res_data, res_tag, res_req_id, err_sync
  );
endinterface
`default_nettype wire

// File: rtl/div_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_arbiter
// Description : Round-robin issue of NUM_REQ sources onto one fixed-latency
//               pipelined divider. A sidecar shift register carries each op's
//               tag/requester alongside the divider; results land in a FIFO
//               whose occupancy plus in-flight count is limited to RES_DEPTH,
//               so a stalled result port can never drop a divider result.
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_arbiter #(
  parameter int XLEN        = 32,
  parameter int DIV_LATENCY = 6,
  parameter int NUM_REQ     = 2,
  parameter int TAG_W       = 6,
  parameter int RES_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  div_issue_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic [ID_W-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]       r_inflight_cnt;
  logic [CNT_W-1:0]       r_fifo_cnt;
  logic [DIV_LATENCY-1:0] r_sc_v;
  logic [DIV_LATENCY-1:0] r_sc_kill;
  logic [ID_W-1:0]        r_sc_id  [DIV_LATENCY];
  logic [TAG_W-1:0]       r_sc_tag [DIV_LATENCY];
  logic [XLEN-1:0]        r_mem_data [RES_DEPTH];
  logic [TAG_W-1:0]       r_mem_tag  [RES_DEPTH];
  logic [ID_W-1:0]        r_mem_id   [RES_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic                   r_err_sync;

  logic [SUM_W-1:0]       w_credits_used;
  logic                   w_issue_ok;
  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_grant_any;
  logic [ID_W-1:0]        w_grant_id;
  logic [XLEN-1:0]        w_dividend;
  logic [XLEN-1:0]        w_divisor;
  logic [1:0]             w_type;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_head_v;
  logic                   w_head_kill;
  logic                   w_capture;
  logic                   w_pop;
  logic                   w_res_valid;

  // Every op in the sidecar or the FIFO holds a result slot; reset blocks issue too.
  assign w_credits_used = SUM_W'(r_inflight_cnt) + SUM_W'(r_fifo_cnt);
  assign w_issue_ok     = !rst && !bus.flush && (w_credits_used < SUM_W'(RES_DEPTH));

  // Round-robin scan starting at r_rr_ptr, first valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (w_issue_ok && !w_grant_any && bus.req_valid[idx]) begin
        w_grant_any     = 1'b1;
        w_grant_id      = ID_W'(idx);
        w_grant[idx]    = 1'b1;
      end
    end
  end

  // Operand mux from the one-hot grant; all zero when nothing is granted.
  always_comb begin
    w_dividend = '0;
    w_divisor  = '0;
    w_type     = '0;
    w_tag      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_dividend = bus.req_dividend[i*XLEN +: XLEN];
        w_divisor  = bus.req_divisor[i*XLEN +: XLEN];
        w_type     = bus.req_type[i*2 +: 2];
        w_tag      = bus.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign bus.req_ready    = w_grant;
  assign bus.div_valid_in = w_grant_any;
  assign bus.div_dividend = w_dividend;
  assign bus.div_divisor  = w_divisor;
  assign bus.div_type     = w_type;

  assign w_head_v    = r_sc_v[DIV_LATENCY-1];
  assign w_head_kill = r_sc_kill[DIV_LATENCY-1];
  // The head lines up with the divider output; a flush discards it as well.
  assign w_capture   = w_head_v && !w_head_kill && !bus.flush;
  assign w_res_valid = (r_fifo_cnt != '0);
  assign w_pop       = w_res_valid && bus.res_ready && !bus.flush;

  // Output fields are forced to zero while the FIFO is empty so reset/flush never expose stale entries.
  assign bus.res_valid  = w_res_valid;
  assign bus.res_data   = w_res_valid ? r_mem_data[r_rptr] : '0;
  assign bus.res_tag    = w_res_valid ? r_mem_tag[r_rptr]  : '0;
  assign bus.res_req_id = w_res_valid ? r_mem_id[r_rptr]   : '0;
  assign bus.err_sync   = r_err_sync;

  // Round-robin pointer advances past the winner; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_any) begin
      r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end
  end

  // Sidecar shift register; a flush marks every live entry as killed as it moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_v    <= '0;
      r_sc_kill <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) begin
        r_sc_id[i]  <= '0;
        r_sc_tag[i] <= '0;
      end
    end else begin
      r_sc_v[0]    <= w_grant_any;
      r_sc_kill[0] <= 1'b0;
      r_sc_id[0]   <= w_grant_id;
      r_sc_tag[0]  <= w_tag;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        r_sc_v[i]    <= r_sc_v[i-1];
        r_sc_kill[i] <= r_sc_kill[i-1] | (bus.flush & r_sc_v[i-1]);
        r_sc_id[i]   <= r_sc_id[i-1];
        r_sc_tag[i]  <= r_sc_tag[i-1];
      end
    end
  end

  // Live in-flight count: +1 on issue, -1 on capture, cleared by flush.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_inflight_cnt <= '0;
    end else begin
      case ({w_grant_any, w_capture})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + 1'b1;
        2'b01:   r_inflight_cnt <= r_inflight_cnt - 1'b1;
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase
    end
  end

  // Result FIFO pointers and occupancy; flush empties it and ignores a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_capture) begin
        r_wptr <= (r_wptr == PTR_W'(RES_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_W'(RES_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_capture, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FIFO storage write; data is taken from the divider whether or not it flagged valid.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem_data[r_wptr] <= bus.div_quotient;
      r_mem_tag[r_wptr]  <= r_sc_tag[DIV_LATENCY-1];
      r_mem_id[r_wptr]   <= r_sc_id[DIV_LATENCY-1];
    end
  end

  // Sticky flag for a divider valid that disagrees with the sidecar head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sync <= 1'b0;
    end else if (bus.div_valid_out != w_head_v) begin
      r_err_sync <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_capture |-> (r_fifo_cnt < CNT_W'(RES_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_div_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_issue_arbiter
// Description : Bench for div_issue_arbiter with a fixed-latency divider model,
//               a queue-based reference of credits, in-flight ops and results,
//               directed scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_arbiter;
  localparam int XLEN = 32;
  localparam int L    = 6;
  localparam int N    = 2;
  localparam int TW   = 6;
  localparam int D    = 8;

  logic clk;
  logic rst;
  logic model_en;
  logic drop_mask;
  int   n_checks;
  int   n_fail;

  div_issue_arbiter_if #(.XLEN(XLEN), .NUM_REQ(N), .TAG_W(TW)) bus ();

  div_issue_arbiter #(.XLEN(XLEN), .DIV_LATENCY(L), .NUM_REQ(N), .TAG_W(TW), .RES_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RISC-V divide semantics, REM/REMU selected by type.
  function automatic logic [31:0] ref_div(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (t)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider model: fixed latency, reset with the block, one valid can be masked.
  logic [L-1:0] dv_pipe;
  logic [31:0]  dq_pipe [L];
  always @(posedge clk) begin
    if (rst) begin
      dv_pipe <= '0;
      for (int i = 0; i < L; i++) dq_pipe[i] <= '0;
    end else begin
      dv_pipe[0] <= bus.div_valid_in;
      dq_pipe[0] <= ref_div(bus.div_type, bus.div_dividend, bus.div_divisor);
      for (int i = 1; i < L; i++) begin
        dv_pipe[i] <= dv_pipe[i-1];
        dq_pipe[i] <= dq_pipe[i-1];
      end
    end
  end
  assign bus.div_valid_out = dv_pipe[L-1] & ~drop_mask;
  assign bus.div_quotient  = dq_pipe[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding ops with their due cycle, and a result queue.
  typedef struct { int due; int id; logic [5:0] tag; logic [31:0] data; bit killed; } op_t;
  typedef struct { logic [31:0] data; logic [5:0] tag; int id; } res_t;
  op_t  m_fl[$];
  res_t m_rq[$];
  int   m_rr;
  int   m_cyc;
  bit   m_err;

  task automatic model_cycle();
    int   used;
    int   g;
    bit   head;
    bit   rv;
    op_t  op;
    res_t r;
    logic [31:0] e_a, e_b;
    logic [1:0]  e_t;
    logic [5:0]  e_tag;
    used = m_rq.size();
    foreach (m_fl[i]) if (!m_fl[i].killed) used++;
    g = -1;
    if (!rst && !bus.flush && used < D) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    e_a = 0; e_b = 0; e_t = 0; e_tag = 0;
    if (g >= 0) begin
      e_a   = bus.req_dividend[g*XLEN +: XLEN];
      e_b   = bus.req_divisor[g*XLEN +: XLEN];
      e_t   = bus.req_type[g*2 +: 2];
      e_tag = bus.req_tag[g*TW +: TW];
    end
    check("m_req_ready", 64'(bus.req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
    check("m_div_valid_in", 64'(bus.div_valid_in), 64'(g >= 0));
    check("m_div_dividend", 64'(bus.div_dividend), 64'(e_a));
    check("m_div_divisor", 64'(bus.div_divisor), 64'(e_b));
    check("m_div_type", 64'(bus.div_type), 64'(e_t));
    rv = (m_rq.size() != 0);
    check("m_res_valid", 64'(bus.res_valid), 64'(rv));
    check("m_res_data", 64'(bus.res_data), rv ? 64'(m_rq[0].data) : 64'd0);
    check("m_res_tag", 64'(bus.res_tag), rv ? 64'(m_rq[0].tag) : 64'd0);
    check("m_res_req_id", 64'(bus.res_req_id), rv ? 64'(m_rq[0].id) : 64'd0);
    check("m_err_sync", 64'(bus.err_sync), 64'(m_err));
    if (rst) begin
      m_fl.delete();
      m_rq.delete();
      m_rr  = 0;
      m_err = 0;
    end else begin
      head = (m_fl.size() > 0) && (m_fl[0].due == m_cyc);
      if (bus.div_valid_out != head) m_err = 1;
      if (rv && bus.res_ready && !bus.flush) void'(m_rq.pop_front());
      if (head) begin
        op = m_fl.pop_front();
        if (!op.killed && !bus.flush) begin
          r.data = op.data; r.tag = op.tag; r.id = op.id;
          m_rq.push_back(r);
        end
      end
      if (bus.flush) begin
        m_rq.delete();
        foreach (m_fl[i]) m_fl[i].killed = 1;
      end
      if (g >= 0) begin
        op.due = m_cyc + L; op.id = g; op.tag = e_tag;
        op.data = ref_div(e_t, e_a, e_b); op.killed = 0;
        m_fl.push_back(op);
        m_rr = (g + 1) % N;
      end
    end
    m_cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_en) model_cycle();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [1:0] t,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
    bus.req_valid[i]                = v;
    bus.req_type[i*2 +: 2]          = t;
    bus.req_dividend[i*XLEN +: XLEN] = a;
    bus.req_divisor[i*XLEN +: XLEN]  = b;
    bus.req_tag[i*TW +: TW]         = tag;
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'b00, 32'd0, 32'd0, 6'd0);
  endtask

  task automatic drain(input int cycles);
    idle_reqs();
    bus.res_ready = 1'b1;
    repeat (cycles) tick();
  endtask

  initial begin
    int cnt;
    int ghosts;
    int idx;
    int got_tags[$];
    n_checks = 0; n_fail = 0;
    model_en = 0; drop_mask = 0; m_rr = 0; m_cyc = 0; m_err = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.res_ready = 1'b0;
    idle_reqs();
    repeat (2) tick();
    model_en = 1;
    @(negedge clk);
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    check("reset_div_valid_in", 64'(bus.div_valid_in), 64'd0);
    check("reset_err_sync", 64'(bus.err_sync), 64'd0);
    tick();
    rst = 1'b0;

    // T1: single DIVU 100/7, result 14 appears seven cycles after issue.
    bus.res_ready = 1'b1;
    set_req(0, 1'b1, 2'b01, 32'd100, 32'd7, 6'd5);
    @(negedge clk);
    check("t1_issue", 64'(bus.div_valid_in), 64'd1);
    check("t1_ready", 64'(bus.req_ready), 64'd1);
    tick();
    idle_reqs();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("t1_early", 64'(bus.res_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("t1_valid", 64'(bus.res_valid), 64'd1);
    check("t1_data", 64'(bus.res_data), 64'd14);
    check("t1_tag", 64'(bus.res_tag), 64'd5);
    check("t1_id", 64'(bus.res_req_id), 64'd0);
    drain(4);

    // T2: both requesters every cycle; pointer sits at 1 after T1.
    got_tags.delete();
    for (int k = 0; k < 30; k++) begin
      if (k < 8) begin
        set_req(0, 1'b1, 2'($urandom), $urandom, $urandom_range(1, 999), 6'(20 + 2*k));
        set_req(1, 1'b1, 2'($urandom), $urandom, $urandom_range(1, 999), 6'(21 + 2*k));
      end else begin
        idle_reqs();
      end
      @(negedge clk);
      if (k < 8) check("t2_grant", 64'(bus.req_ready), (k % 2 == 0) ? 64'd2 : 64'd1);
      if (bus.res_valid && bus.res_ready) got_tags.push_back(int'(bus.res_tag));
      tick();
    end
    check("t2_count", 64'(got_tags.size()), 64'd8);
    for (int k = 0; k < 8 && k < got_tags.size(); k++)
      check("t2_order", 64'(got_tags[k]), 64'(20 + 2*k + ((k % 2 == 0) ? 1 : 0)));
    drain(4);

    // T3: stalled result port limits issue to RES_DEPTH; one pop frees one slot.
    bus.res_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      set_req(0, 1'b1, 2'b01, $urandom, 32'd3, 6'(k));
      set_req(1, 1'b1, 2'b11, $urandom, 32'd5, 6'(k + 32));
      @(negedge clk);
      if (bus.div_valid_in) cnt++;
      if (k == 19) check("t3_blocked", 64'(bus.req_ready), 64'd0);
      tick();
    end
    check("t3_issues", 64'(cnt), 64'd8);
    cnt = 0;
    for (int k = 0; k < 13; k++) begin
      bus.res_ready = (k == 0);
      @(negedge clk);
      if (bus.div_valid_in) cnt++;
      tick();
    end
    check("t3_one_more", 64'(cnt), 64'd1);
    drain(16);

    // T4: two results queued, three in flight, then flush.
    bus.res_ready = 1'b0;
    ghosts = 0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0 || c == 1 || c == 4 || c == 5 || c == 6) begin
        set_req(0, 1'b1, 2'b00, $urandom, $urandom_range(1, 50), 6'(40 + idx));
        idx++;
      end else begin
        idle_reqs();
      end
      bus.flush = (c == 8);
      bus.res_ready = (c > 8);
      @(negedge clk);
      if (c == 8) check("t4_queued", 64'(bus.res_valid), 64'd1);
      if (c == 9) check("t4_cleared", 64'(bus.res_valid), 64'd0);
      if (c >= 9 && bus.res_valid) ghosts++;
      tick();
    end
    bus.flush = 1'b0;
    check("t4_ghosts", 64'(ghosts), 64'd0);
    check("t4_err", 64'(bus.err_sync), 64'd0);
    bus.res_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      set_req(0, 1'b1, 2'b01, $urandom, 32'd9, 6'(k));
      @(negedge clk);
      if (bus.div_valid_in) cnt++;
      tick();
    end
    check("t4_credits", 64'(cnt), 64'd8);
    drain(16);

    // T5: divider loses one valid_out; err_sync latches.
    for (int c = 0; c < 14; c++) begin
      if (c == 0) set_req(1, 1'b1, 2'b01, 32'd50, 32'd5, 6'd9);
      else idle_reqs();
      drop_mask = (c == 6);
      @(negedge clk);
      if (c == 6) check("t5_before", 64'(bus.err_sync), 64'd0);
      if (c >= 7) check("t5_sticky", 64'(bus.err_sync), 64'd1);
      tick();
    end
    drop_mask = 1'b0;

    // T6: reset with ops in flight.
    bus.res_ready = 1'b1;
    ghosts = 0;
    for (int c = 0; c < 27; c++) begin
      idle_reqs();
      if (c < 4) set_req(c % 2, 1'b1, 2'b01, $urandom, 32'd11, 6'(c + 1));
      if (c == 26) begin
        set_req(0, 1'b1, 2'b01, 32'd8, 32'd2, 6'd1);
        set_req(1, 1'b1, 2'b01, 32'd8, 32'd2, 6'd2);
      end
      rst = (c == 4 || c == 5);
      @(negedge clk);
      if (c == 5) begin
        check("t6_res_valid", 64'(bus.res_valid), 64'd0);
        check("t6_res_data", 64'(bus.res_data), 64'd0);
        check("t6_res_tag", 64'(bus.res_tag), 64'd0);
        check("t6_req_ready", 64'(bus.req_ready), 64'd0);
        check("t6_div_valid_in", 64'(bus.div_valid_in), 64'd0);
        check("t6_err", 64'(bus.err_sync), 64'd0);
      end
      if (c >= 6 && c < 26 && bus.res_valid) ghosts++;
      if (c == 26) check("t6_rr_zero", 64'(bus.req_ready), 64'd1);
      tick();
    end
    check("t6_ghosts", 64'(ghosts), 64'd0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 99) < 60), 2'($urandom),
                ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom,
                ($urandom_range(0, 15) == 0) ? 32'd0 :
                ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom_range(1, 70000),
                6'($urandom));
      end
      bus.res_ready = ($urandom_range(0, 99) < 70);
      bus.flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus.flush = 1'b0;
    drain(20);
    @(negedge clk);
    check("final_err", 64'(bus.err_sync), 64'd0);
    check("final_empty", 64'(bus.res_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
